// File: rtl/fp_posit_pkg.sv
// Shared types and widths for the fp_posit accumulator sequencer.
package fp_posit_pkg;

  localparam int unsigned EXP_W       = 5;
  localparam int unsigned FRAC_W      = 14;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned LEN_W_DEF   = 5;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_t;

  // One product term as presented to the accumulator.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [FRAC_W-1:0] frac;
  } term_t;

endpackage

// File: rtl/acc_done_edge.sv
// Rising-edge detector on the accumulator done level plus the per-term
// wait counter that flags a stuck accumulator.
module acc_done_edge #(
  parameter int unsigned TIMEOUT = fp_posit_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic acc_done,
  input  logic wait_en,
  input  logic clr,
  output logic done_rise_c,
  output logic timeout_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic             acc_done_q;
  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_done_q <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      acc_done_q <= acc_done;
      if (clr) begin
        wait_cnt_q <= '0;
      end else if (wait_en && !timeout_c) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end
  end

  // A level left high from the previous term must not count as completion.
  assign done_rise_c = acc_done & ~acc_done_q;
  assign timeout_c   = (wait_cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/fp_posit_acc_ctrl.sv
// Sequencer for the fp_posit_acc shift-and-add accumulator: one dot-product
// pass of cfg_len terms, owning the running sum fed back to the accumulator.
module fp_posit_acc_ctrl
  import fp_posit_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [EXP_W-1:0]  cfg_exp_set,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  output logic              acc_start,
  output logic              acc_sign,
  output logic [EXP_W-1:0]  acc_exp_set,
  output logic [EXP_W-1:0]  acc_exp_in,
  output logic [FRAC_W-1:0] acc_fixed_in,
  output logic [ACC_W-1:0]  acc_fixed_acc,
  input  logic [ACC_W-1:0]  acc_fixed_out,
  input  logic [EXP_W-1:0]  acc_exp_out,
  input  logic              acc_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_sum,
  output logic [EXP_W-1:0]  res_exp,
  output logic              busy,
  output logic              err
);

  state_t             state_q, state_nx;
  term_t              term_q, term_nx;
  logic [LEN_W-1:0]   len_q, len_nx;
  logic [LEN_W-1:0]   count_q, count_nx;
  logic [LEN_W-1:0]   count_inc_c;
  logic [EXP_W-1:0]   exp_set_q, exp_set_nx;
  logic [ACC_W-1:0]   sum_q, sum_nx;
  logic               err_q, err_nx;
  logic               in_ready_q, in_ready_nx;
  logic               acc_start_q, acc_start_nx;
  logic               res_valid_q, res_valid_nx;
  logic               busy_q, busy_nx;
  logic               wait_en_c, clr_c;
  logic               done_rise_c, timeout_c;
  logic               unused_exp_out;

  // The result exponent is the captured shared exponent; the accumulator's copy is redundant.
  assign unused_exp_out = ^acc_exp_out;

  assign wait_en_c = (state_q == WAIT);
  assign clr_c     = (state_q == ISSUE);

  acc_done_edge #(
    .TIMEOUT (TIMEOUT)
  ) u_acc_done_edge (
    .clk         (clk),
    .rst         (rst),
    .acc_done    (acc_done),
    .wait_en     (wait_en_c),
    .clr         (clr_c),
    .done_rise_c (done_rise_c),
    .timeout_c   (timeout_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      term_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      exp_set_q   <= '0;
      sum_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      acc_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_nx;
      term_q      <= term_nx;
      len_q       <= len_nx;
      count_q     <= count_nx;
      exp_set_q   <= exp_set_nx;
      sum_q       <= sum_nx;
      err_q       <= err_nx;
      in_ready_q  <= in_ready_nx;
      acc_start_q <= acc_start_nx;
      res_valid_q <= res_valid_nx;
      busy_q      <= busy_nx;
    end
  end

  assign count_inc_c = count_q + LEN_W'(1);

  always_comb begin
    state_nx   = state_q;
    term_nx    = term_q;
    len_nx     = len_q;
    count_nx   = count_q;
    exp_set_nx = exp_set_q;
    sum_nx     = sum_q;
    err_nx     = err_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          len_nx     = cfg_len;
          exp_set_nx = cfg_exp_set;
          sum_nx     = '0;
          count_nx   = '0;
          err_nx     = 1'b0;
          state_nx   = (cfg_len == '0) ? RESULT : FETCH;
        end
      end
      FETCH: begin
        if (in_valid) begin
          term_nx  = '{sign: in_sign, expo: in_exp, frac: in_frac};
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        // A completion on the timeout cycle still counts.
        if (done_rise_c) begin
          sum_nx   = acc_fixed_out;
          count_nx = count_inc_c;
          state_nx = (count_inc_c == len_q) ? RESULT : FETCH;
        end else if (timeout_c) begin
          err_nx   = 1'b1;
          state_nx = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Handshake/control outputs are registered copies of the next state.
    in_ready_nx  = (state_nx == FETCH);
    acc_start_nx = (state_nx == ISSUE);
    res_valid_nx = (state_nx == RESULT);
    busy_nx      = (state_nx != IDLE);
  end

  // Term and sum registers only change in FETCH/WAIT, so they are stable through ISSUE and WAIT.
  assign in_ready      = in_ready_q;
  assign acc_start     = acc_start_q;
  assign acc_sign      = term_q.sign;
  assign acc_exp_in    = term_q.expo;
  assign acc_fixed_in  = term_q.frac;
  assign acc_exp_set   = exp_set_q;
  assign acc_fixed_acc = sum_q;
  assign res_valid     = res_valid_q;
  assign res_sum       = sum_q;
  assign res_exp       = exp_set_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_fp_posit_acc_ctrl.sv
// Directed bench for fp_posit_acc_ctrl with a behavioural shift-and-add accumulator.
module tb_fp_posit_acc_ctrl;
  import fp_posit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic [4:0]  cfg_len = '0;
  logic [4:0]  cfg_exp_set = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [13:0] in_frac = '0;
  logic        acc_start, acc_sign;
  logic [4:0]  acc_exp_set, acc_exp_in;
  logic [13:0] acc_fixed_in;
  logic [31:0] acc_fixed_acc, acc_fixed_out;
  logic [4:0]  acc_exp_out;
  logic        acc_done;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_sum;
  logic [4:0]  res_exp;
  logic        busy, err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_posit_acc_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .cfg_len(cfg_len), .cfg_exp_set(cfg_exp_set),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
    .in_frac(in_frac), .acc_start(acc_start), .acc_sign(acc_sign),
    .acc_exp_set(acc_exp_set), .acc_exp_in(acc_exp_in), .acc_fixed_in(acc_fixed_in),
    .acc_fixed_acc(acc_fixed_acc), .acc_fixed_out(acc_fixed_out),
    .acc_exp_out(acc_exp_out), .acc_done(acc_done), .res_valid(res_valid),
    .res_ready(res_ready), .res_sum(res_sum), .res_exp(res_exp), .busy(busy), .err(err)
  );

  // Accumulator model: operands captured on start, sign one cycle later.
  int          acc_lat = 1;
  logic        acc_dead = 1'b0;
  logic        m_done, m_sign, m_sign_late;
  logic [31:0] m_acc, m_term;
  int          m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_done <= 1'b0; m_sign <= 1'b0; m_sign_late <= 1'b0;
      m_acc <= '0; m_term <= '0; m_cnt <= 0;
    end else begin
      m_sign_late <= acc_start;
      if (m_sign_late) m_sign <= acc_sign;
      if (acc_start) begin
        m_done <= 1'b0;
        m_cnt  <= acc_lat;
        m_acc  <= acc_fixed_acc;
        m_term <= 32'(acc_fixed_in) << (acc_exp_in - acc_exp_set);
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !acc_dead) m_done <= 1'b1;
      end
    end
  end

  assign acc_done      = m_done;
  assign acc_fixed_out = m_sign ? (m_acc - m_term) : (m_acc + m_term);
  assign acc_exp_out   = acc_exp_set;

  typedef struct packed {
    logic [4:0]       len;
    logic [4:0]       exp_set;
    logic [2:0]       sg;
    logic [2:0][4:0]  ex;
    logic [2:0][13:0] fr;
    logic [31:0]      want_sum;
    logic [4:0]       want_exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, want);
    end
  endtask

  task automatic start_pass(input logic [4:0] len, input logic [4:0] es);
    go = 1'b1; cfg_len = len; cfg_exp_set = es;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic send_term(input logic s, input logic [4:0] e, input logic [13:0] f);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready before term", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_frac = f;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    chk("res_valid reached", 32'(res_valid), 32'd1);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("busy after accept", 32'(busy), 32'd0);
    chk("res_valid after accept", 32'(res_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{len: 5'd1, exp_set: 5'd3, sg: 3'b000, ex: {5'd0, 5'd0, 5'd3},
                fr: {14'd0, 14'd0, 14'h0100}, want_sum: 32'h0000_0100, want_exp: 5'd3};
    vecs[1] = '{len: 5'd3, exp_set: 5'd3, sg: 3'b100, ex: {5'd3, 5'd4, 5'd3},
                fr: {14'h08, 14'h10, 14'h10}, want_sum: 32'h0000_0028, want_exp: 5'd3};
    vecs[2] = '{len: 5'd2, exp_set: 5'd0, sg: 3'b001, ex: {5'd0, 5'd0, 5'd0},
                fr: {14'd0, 14'd0, 14'd1}, want_sum: 32'hFFFF_FFFF, want_exp: 5'd0};
    vecs[3] = '{len: 5'd2, exp_set: 5'd2, sg: 3'b000, ex: {5'd0, 5'd2, 5'd5},
                fr: {14'd0, 14'd1, 14'h3FFF}, want_sum: 32'h0001_FFF9, want_exp: 5'd2};
    vecs[4] = '{len: 5'd0, exp_set: 5'd7, sg: 3'b000, ex: '0,
                fr: '0, want_sum: 32'h0, want_exp: 5'd7};

    // Reset state
    #3;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst acc_start", 32'(acc_start), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst res_sum", res_sum, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Zero-length pass: result the cycle after go; go in RESULT ignored
    start_pass(5'd0, 5'd7);
    chk("len0 res_valid next cycle", 32'(res_valid), 32'd1);
    chk("len0 res_sum", res_sum, 32'd0);
    chk("len0 res_exp", 32'(res_exp), 32'd7);
    start_pass(5'd4, 5'd1);
    chk("go in RESULT ignored valid", 32'(res_valid), 32'd1);
    chk("go in RESULT ignored exp", 32'(res_exp), 32'd7);
    chk("go in RESULT in_ready", 32'(in_ready), 32'd0);
    release_res();

    // Go while busy is ignored; result holds under back-pressure
    start_pass(5'd1, 5'd3);
    send_term(1'b0, 5'd3, 14'd5);
    start_pass(5'd3, 5'd9);
    wait_res(cyc);
    chk("busy-go res_sum", res_sum, 32'd5);
    chk("busy-go res_exp", 32'(res_exp), 32'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall res_valid", 32'(res_valid), 32'd1);
      chk("stall res_sum", res_sum, 32'd5);
    end
    release_res();
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle in_ready", 32'(in_ready), 32'd0);

    // Asynchronous reset in the middle of WAIT
    acc_lat = 6;
    start_pass(5'd1, 5'd2);
    send_term(1'b0, 5'd4, 14'h55);
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    chk("pre-reset acc_fixed_in", 32'(acc_fixed_in), 32'h55);
    #2 rst = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst acc_fixed_in", 32'(acc_fixed_in), 32'd0);
    chk("async rst acc_exp_in", 32'(acc_exp_in), 32'd0);
    chk("async rst acc_exp_set", 32'(acc_exp_set), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    acc_lat = 1;
    @(negedge clk);

    // Accumulator never completes: timeout after TIMEOUT wait cycles
    acc_dead = 1'b1;
    start_pass(5'd2, 5'd0);
    send_term(1'b0, 5'd0, 14'd7);
    wait_res(cyc);
    chk("timeout cycles", 32'(cyc), 32'(TIMEOUT_DEF + 2));
    chk("timeout err", 32'(err), 32'd1);
    chk("timeout res_sum", res_sum, 32'd0);
    release_res();
    chk("err sticky in IDLE", 32'(err), 32'd1);
    acc_dead = 1'b0;

    // Table-driven passes; first one also shows go clears err
    for (int v = 0; v < 5; v++) begin
      start_pass(vecs[v].len, vecs[v].exp_set);
      chk($sformatf("vec%0d err cleared", v), 32'(err), 32'd0);
      for (int t = 0; t < int'(vecs[v].len); t++)
        send_term(vecs[v].sg[t], vecs[v].ex[t], vecs[v].fr[t]);
      wait_res(cyc);
      chk($sformatf("vec%0d res_sum", v), res_sum, vecs[v].want_sum);
      chk($sformatf("vec%0d res_exp", v), 32'(res_exp), 32'(vecs[v].want_exp));
      chk($sformatf("vec%0d err", v), 32'(err), 32'd0);
      chk($sformatf("vec%0d in_ready", v), 32'(in_ready), 32'd0);
      release_res();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
